// File: rtl/lane_collision_ctrl.sv
// Lane-crossing game controller: per-frame frog/obstacle overlap counting, lives, score, game FSM.
// Optional LANE_COLLISION_GOD_MODE_EN: PLAY hits are reported but never cost lives.

module lane_collision_sticky (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_set,
  output logic o_q
);
  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst)     o_q <= 1'b0;
    else if (i_clr) o_q <= 1'b0;
    else if (i_set) o_q <= 1'b1;
endmodule

module lane_collision_ctrl #(
  parameter int N_LANES        = 5,
  parameter int LIVES          = 3,
  parameter int HIT_THRESH     = 4,
  parameter int RESPAWN_FRAMES = 60,
  parameter int GOAL_Y         = 40,
  parameter int SCORE_W        = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_pix_stb,
  input  logic               i_animate,
  input  logic               i_start,
  input  logic               i_frog_px,
  input  logic [N_LANES-1:0] i_lane_px,
  input  logic [N_LANES-1:0] i_lane_en,
  input  logic [11:0]        i_frog_y1,
  output logic [1:0]         o_state,
  output logic               o_dead,
  output logic               o_respawn,
  output logic [3:0]         o_lives,
  output logic [SCORE_W-1:0] o_score,
  output logic [N_LANES-1:0] o_hit_lane,
  output logic               o_frame_hit
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PLAY = 2'd1, S_DYING = 2'd2, S_OVER = 2'd3} state_t;

  state_t             state;
  logic [7:0]         ov_cnt;
  logic [7:0]         rcnt;
  logic [N_LANES-1:0] mask;
  logic [N_LANES-1:0] lane_px_en;
  logic               qual, hit, goal;

  assign lane_px_en = i_lane_px & i_lane_en;
  assign qual       = i_pix_stb & i_frog_px;
  assign hit        = ov_cnt >= 8'(HIT_THRESH);
  assign goal       = i_frog_y1 <= 12'(GOAL_Y);

  // One sticky bit per lane; end-of-frame clear takes priority over a same-cycle pixel.
  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    lane_collision_sticky u_sticky (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_clr (i_animate),
      .i_set (qual & lane_px_en[k]),
      .o_q   (mask[k])
    );
  end

  assign o_state = state;
  assign o_dead  = state[1];  // DYING and OVER share the top encoding bit

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state       <= S_IDLE;
      ov_cnt      <= 8'd0;
      rcnt        <= 8'd0;
      o_lives     <= 4'd0;
      o_score     <= '0;
      o_respawn   <= 1'b0;
      o_hit_lane  <= '0;
      o_frame_hit <= 1'b0;
    end else begin
      o_respawn <= 1'b0;
      if (i_animate) begin
        o_frame_hit <= hit;
        o_hit_lane  <= mask;
        ov_cnt      <= 8'd0;
      end else if (qual && (|lane_px_en) && !hit) begin
        ov_cnt <= ov_cnt + 8'd1;
      end

      // Respawn requests are gated on the previous pulse so it can never stretch to two cycles.
      case (state)
        S_IDLE, S_OVER: if (i_start) begin
          state     <= S_PLAY;
          o_lives   <= 4'(LIVES);
          o_score   <= '0;
          o_respawn <= ~o_respawn;
        end
        S_PLAY: if (i_animate) begin
`ifdef LANE_COLLISION_GOD_MODE_EN
          if (!hit && goal) begin
            if (o_score != '1) o_score <= o_score + 1'b1;
            o_respawn <= ~o_respawn;
          end
`else
          if (hit) begin
            o_lives <= o_lives - 4'd1;
            if (o_lives <= 4'd1) state <= S_OVER;
            else begin
              state <= S_DYING;
              rcnt  <= 8'(RESPAWN_FRAMES);
            end
          end else if (goal) begin
            if (o_score != '1) o_score <= o_score + 1'b1;
            o_respawn <= ~o_respawn;
          end
`endif
        end
        S_DYING: if (i_animate) begin
          rcnt <= rcnt - 8'd1;
          if (rcnt <= 8'd1) begin
            state     <= S_PLAY;
            o_respawn <= ~o_respawn;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lane_collision_ctrl.sv
// Directed test-plan sequence followed by randomized play, checked against a frame-level game model.
module tb_lane_collision_ctrl;
  localparam int NL = 5, LV = 3, TH = 4, RF = 60, GY = 40;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          pix_stb = 0, animate = 0, start = 0, frog_px = 0;
  logic [NL-1:0] lane_px = '0, lane_en = '1;
  logic [11:0]   frog_y = 12'd200;
  logic [1:0]    st;
  logic          dead, respawn, frame_hit;
  logic [3:0]    lives;
  logic [7:0]    score;
  logic [NL-1:0] hit_lane;

  int n_tests = 0, n_fail = 0;

  // reference model state
  int            m_state, m_lives, m_score, m_frames, m_pix;
  logic [NL-1:0] m_sticky, m_hl;
  bit            m_fh, m_resp;

  lane_collision_ctrl #(.N_LANES(NL), .LIVES(LV), .HIT_THRESH(TH), .RESPAWN_FRAMES(RF),
                        .GOAL_Y(GY), .SCORE_W(8)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_pix_stb(pix_stb), .i_animate(animate), .i_start(start),
    .i_frog_px(frog_px), .i_lane_px(lane_px), .i_lane_en(lane_en), .i_frog_y1(frog_y),
    .o_state(st), .o_dead(dead), .o_respawn(respawn), .o_lives(lives), .o_score(score),
    .o_hit_lane(hit_lane), .o_frame_hit(frame_hit));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_lives = 0; m_score = 0; m_frames = 0; m_pix = 0;
    m_sticky = '0; m_hl = '0; m_fh = 0; m_resp = 0;
  endtask

  task automatic model_step();
    bit frame_is_hit, want;
    logic [NL-1:0] lit;
    frame_is_hit = (m_pix >= TH);
    lit = lane_px & lane_en;
    want = 0;
    if (animate) begin
      m_fh = frame_is_hit; m_hl = m_sticky; m_pix = 0; m_sticky = '0;
    end else if (pix_stb && frog_px) begin
      if (lit != '0) m_pix++;
      m_sticky |= lit;
    end
    case (m_state)
      0, 3: if (start) begin m_state = 1; m_lives = LV; m_score = 0; want = 1; end
      1: if (animate) begin
`ifdef LANE_COLLISION_GOD_MODE_EN
        if (!frame_is_hit && frog_y <= GY) begin
          m_score = (m_score < 255) ? m_score + 1 : 255; want = 1;
        end
`else
        if (frame_is_hit) begin
          m_lives--;
          if (m_lives == 0) m_state = 3;
          else begin m_state = 2; m_frames = RF; end
        end else if (frog_y <= GY) begin
          m_score = (m_score < 255) ? m_score + 1 : 255; want = 1;
        end
`endif
      end
      2: if (animate) begin
        m_frames--;
        if (m_frames == 0) begin m_state = 1; want = 1; end
      end
      default: ;
    endcase
    m_resp = want && !m_resp;
  endtask

  task automatic compare_all();
    chk("state", st, m_state);
    chk("dead", dead, (m_state >= 2));
    chk("respawn", respawn, m_resp);
    chk("lives", lives, m_lives);
    chk("score", score, m_score);
    chk("hit_lane", hit_lane, m_hl);
    chk("frame_hit", frame_hit, m_fh);
  endtask

  task automatic cyc(input bit s, input bit f, input logic [NL-1:0] lp, input bit an,
                     input bit go, input logic [11:0] y);
    pix_stb = s; frog_px = f; lane_px = lp; animate = an; start = go; frog_y = y;
    @(posedge clk);
    model_step();
    #1 compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2 model_reset();
    compare_all();
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic pixels(input int n, input logic [NL-1:0] lp, input logic [11:0] y);
    for (int i = 0; i < n; i++) cyc(1, 1, lp, 0, 0, y);
  endtask

  task automatic frame_end(input logic [11:0] y);
    cyc(0, 0, '0, 1, 0, y);
    cyc(0, 0, '0, 0, 0, y);
  endtask

  initial begin
    model_reset();
    #12 compare_all();
    @(negedge clk) rst_n = 1'b1;

    // start from IDLE
    cyc(0, 0, '0, 0, 1, 200);
    chk("tp_start_state", st, 1); chk("tp_start_lives", lives, 3);
    chk("tp_start_resp", respawn, 1); chk("tp_start_dead", dead, 0);
    cyc(0, 0, '0, 0, 0, 200);
    chk("tp_resp_once", respawn, 0);

    // below-threshold then threshold frame on lane 2
    pixels(3, 5'b00100, 200); frame_end(200);
    chk("tp_3px_fh", frame_hit, 0); chk("tp_3px_hl", hit_lane, 5'b00100); chk("tp_3px_lives", lives, 3);
    pixels(4, 5'b00100, 200); frame_end(200);
`ifndef LANE_COLLISION_GOD_MODE_EN
    chk("tp_4px_fh", frame_hit, 1); chk("tp_4px_lives", lives, 2);
    chk("tp_4px_state", st, 2); chk("tp_4px_dead", dead, 1);

    // DYING: overlap is harmless, respawn after the 60th frame
    pixels(6, 5'b00010, 200);
    for (int i = 0; i < RF - 1; i++) frame_end(200);
    chk("tp_dying_lives", lives, 2); chk("tp_dying_state", st, 2);
    cyc(0, 0, '0, 1, 0, 200);
    chk("tp_respawn", respawn, 1); chk("tp_play_again", st, 1); chk("tp_alive", dead, 0);
    cyc(0, 0, '0, 0, 0, 200);

    // goal, then goal frame with a hit
    frame_end(40);
    chk("tp_goal_score", score, 1);
    pixels(4, 5'b01000, 40); frame_end(40);
    chk("tp_goalhit_score", score, 1); chk("tp_goalhit_lives", lives, 1);
    for (int i = 0; i < RF; i++) frame_end(200);
    pixels(5, 5'b10000, 200); frame_end(200);
    chk("tp_over_lives", lives, 0); chk("tp_over_state", st, 3); chk("tp_over_dead", dead, 1);
    cyc(0, 0, '0, 0, 1, 200);
    chk("tp_restart_state", st, 1); chk("tp_restart_lives", lives, 3); chk("tp_restart_score", score, 0);
    cyc(0, 0, '0, 0, 0, 200);
`endif

    // disabled lane never counts
    lane_en = 5'b11110;
    pixels(100, 5'b00001, 200); frame_end(200);
    chk("tp_dis_fh", frame_hit, 0); chk("tp_dis_hl", hit_lane, 0);
    lane_en = '1;
    pixels(2, 5'b00001, 200);
    do_reset();
    chk("tp_rst_state", st, 0); chk("tp_rst_lives", lives, 0);

    // randomized play
    for (int i = 0; i < 15000; i++) begin
      if ($urandom_range(0, 2999) == 0) do_reset();
      lane_en = ($urandom_range(0, 3) == 0) ? NL'($urandom) : '1;
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, NL'($urandom),
          $urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0, 12'($urandom_range(0, 90)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/lane_collision_ctrl.md
Name: lane_collision_ctrl

Overview:
- Parametrised game controller for the lane-crossing VGA game.
- Replaces the single-cycle "frog pixel AND any square pixel" dead flag with several pieces of state:
  - per-frame pixel-overlap counting across N lanes, with a per-lane lethal mask;
  - a lives counter and a respawn delay;
  - goal detection and a saturating score;
  - a four-state game FSM.
- Sits between the per-pixel shape tests and the frog animator. o_dead drives the frog's i_dead; o_respawn returns the frog to its start position.

Parameters:
- N_LANES, 5, number of obstacle lanes (1..16).
- LIVES, 3, lives loaded on start (1..15).
- HIT_THRESH, 4, overlapping frog/obstacle pixels in one frame needed to register a hit (1..255).
- RESPAWN_FRAMES, 60, frames spent in DYING before respawn (1..255).
- GOAL_Y, 40, frog top edge at or above this row counts as reaching home.
- SCORE_W, 8, score width.

Ports:
- i_clk  in  1  system clock (100 MHz).
- i_rst  in  1  reset, asynchronous, active-low.
- i_pix_stb  in  1  pixel strobe; pixel inputs are sampled only when high.
- i_animate  in  1  one-cycle end-of-frame pulse (blanking).
- i_start  in  1  start/restart request, level-sampled.
- i_frog_px  in  1  current pixel lies inside the frog.
- i_lane_px  in  N_LANES  current pixel lies inside an obstacle of lane k.
- i_lane_en  in  N_LANES  lane k is lethal when its bit is 1.
- i_frog_y1  in  12  frog top edge.
- o_state  out  2  game state: 0=IDLE, 1=PLAY, 2=DYING, 3=OVER.
- o_dead  out  1  high in DYING and in OVER.
- o_respawn  out  1  one-cycle pulse.
- o_lives  out  4  remaining lives.
- o_score  out  SCORE_W  homes reached.
- o_hit_lane  out  N_LANES  lanes that overlapped the frog in the last evaluated frame.
- o_frame_hit  out  1  last evaluated frame registered a hit.

Behaviour:
- Reset (asynchronous, i_rst=0) sets:
  - state IDLE; o_lives=0; o_score=0; o_dead=0; o_respawn=0;
  - o_hit_lane=0; o_frame_hit=0; overlap counter and sticky lane mask cleared; respawn counter 0.
- Reset mid-frame or mid-DYING discards all in-flight counts. Outputs are registered.
- Overlap accumulation, in every state:
  - When i_pix_stb & i_frog_px & |(i_lane_px & i_lane_en) is true, the 8-bit overlap counter increments, saturating at HIT_THRESH.
  - When i_pix_stb & i_frog_px is true, the sticky mask ORs in (i_lane_px & i_lane_en).
- Frame evaluation, on the i_animate cycle:
  - o_frame_hit <= (count >= HIT_THRESH).
  - o_hit_lane <= sticky mask.
  - Counter and mask clear.
  - A pixel qualifying in the same cycle is discarded; clear wins.
- IDLE:
  - i_start=1 -> PLAY next cycle, o_lives=LIVES, o_score=0, o_respawn pulses once.
- PLAY, at i_animate:
  - Hit (count >= HIT_THRESH):
    - o_lives decrements.
    - If the new value is 0 -> OVER; otherwise -> DYING, with the respawn counter loaded to RESPAWN_FRAMES.
  - No hit and i_frog_y1 <= GOAL_Y: o_score increments (saturating at all-ones), o_respawn pulses, state stays PLAY.
  - Hit and goal in the same frame: the hit wins and the score is unchanged.
  - i_start is ignored in PLAY.
- DYING:
  - Each i_animate decrements the respawn counter.
  - When the counter reaches 0: o_respawn pulses, state -> PLAY the same cycle.
  - Hits evaluated while in DYING update o_frame_hit and o_hit_lane only; they never cost lives.
- OVER:
  - o_dead is held at 1.
  - i_start=1 -> PLAY with lives and score reloaded as from IDLE, and an o_respawn pulse.
- o_respawn is never high for two consecutive cycles.
- Lanes with i_lane_en=0 never contribute to hits or to o_hit_lane.

Optional Feature:
- Macro: LANE_COLLISION_GOD_MODE_EN.
- When defined:
  - A PLAY hit still sets o_frame_hit and o_hit_lane.
  - o_lives is not decremented and the state stays PLAY, so there is no DYING entry.
  - Goal scoring is suppressed in any frame that registers a hit.
- When undefined: behaviour is exactly as in Behaviour above. The macro removes no ports.

Test Plan:
- Reset then i_start=1 for one cycle -> o_state=1, o_lives=3, o_score=0, exactly one o_respawn pulse, o_dead=0.
- PLAY; frame with 3 qualifying pixels on lane 2, then i_animate -> o_frame_hit=0, o_hit_lane=5'b00100, o_lives=3. Next frame with 4 pixels -> o_frame_hit=1, o_lives=2, o_state=2, o_dead=1.
- DYING with RESPAWN_FRAMES=60: after exactly 60 i_animate pulses -> o_respawn pulse, o_state=1, o_dead=0. A hit-level overlap during DYING leaves o_lives=2.
- i_frog_y1=40, no overlap, i_animate -> o_score=1 plus a respawn pulse. Same frame with 4 overlap pixels -> o_score unchanged, o_lives decremented.
- Three hits from start -> o_lives=0, o_state=3, o_dead=1. i_start -> o_state=1, o_lives=3, o_score=0.
- i_lane_en=0 for lane 0, 100 overlap pixels on lane 0 -> o_frame_hit=0, o_hit_lane=0. Assert i_rst=0 mid-frame, then release -> all outputs at reset values, o_state=0.
